// File: rtl/fft32_frame_ctrl.sv
// fft32_frame_ctrl: packs serial samples into 32-point frames for fft32_top, meters frames with credits,
// double-buffers the parallel results and replays them as a serial valid/ready bin stream.
module fft32_frame_ctrl #(
    parameter int N       = 32,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 11,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IN_W-1:0]    s_data,
    input  logic               s_last,
    output logic               fft_in_valid,
    output logic [N*IN_W-1:0]  fft_in_real,
    input  logic               fft_out_valid,
    input  logic [N*OUT_W-1:0] fft_out_real,
    input  logic [N*OUT_W-1:0] fft_out_imag,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_real,
    output logic [OUT_W-1:0]   m_imag,
    output logic [4:0]         m_index,
    output logic               m_last,
    output logic               err_align,
    output logic               err_timeout,
    output logic               err_spurious
);
    localparam logic [1:0] COLLECT     = 2'd0;
    localparam logic [1:0] WAIT_CREDIT = 2'd1;
    localparam logic [1:0] LAUNCH      = 2'd2;
    localparam int         WD_W        = $clog2(TIMEOUT + 1);

    logic [1:0]         state, state_n;
    logic [4:0]         count;
    logic [1:0]         inflight, inflight_n, obuf_count, obuf_n;
    logic               wr_ptr, rd_ptr;
    logic [WD_W-1:0]    wd, wd_n;
    logic [N*OUT_W-1:0] obuf_re [2];
    logic [N*OUT_W-1:0] obuf_im [2];
    logic               s_hs, misalign, launch, capture, retire, trip, credit, credit_n;

    assign s_ready      = state == COLLECT;
    assign s_hs         = s_valid && s_ready;
    assign misalign     = s_hs && s_last && count != 5'd31;
    assign launch       = state == LAUNCH;
    assign fft_in_valid = launch;
    assign capture      = fft_out_valid && inflight != 2'd0;
    assign m_valid      = obuf_count != 2'd0;
    assign retire       = m_valid && m_ready && m_index == 5'd31;
    assign trip         = inflight != 2'd0 && !fft_out_valid && wd == WD_W'(TIMEOUT - 1);
    assign m_real       = obuf_re[rd_ptr][m_index*OUT_W +: OUT_W];
    assign m_imag       = obuf_im[rd_ptr][m_index*OUT_W +: OUT_W];
    assign m_last       = m_valid && m_index == 5'd31;

    // WAIT_CREDIT looks at the post-edge occupancy so a freed buffer launches on the very next cycle
    always_comb begin
        inflight_n = trip ? {1'b0, launch} : inflight + {1'b0, launch} - {1'b0, capture};
        obuf_n     = obuf_count + {1'b0, capture} - {1'b0, retire};
        credit     = {1'b0, inflight} + {1'b0, obuf_count} < 3'd2;
        credit_n   = {1'b0, inflight_n} + {1'b0, obuf_n} < 3'd2;
        state_n    = (state == LAUNCH)        ? COLLECT :
                     (state == WAIT_CREDIT)   ? (credit_n ? LAUNCH : WAIT_CREDIT) :
                     (s_hs && count == 5'd31) ? (credit ? LAUNCH : WAIT_CREDIT) : COLLECT;
        wd_n       = (inflight == 2'd0 || fft_out_valid || trip) ? '0 : wd + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= COLLECT;
            count        <= '0;
            inflight     <= '0;
            obuf_count   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            wd           <= '0;
            fft_in_real  <= '0;
            obuf_re[0]   <= '0;
            obuf_re[1]   <= '0;
            obuf_im[0]   <= '0;
            obuf_im[1]   <= '0;
            m_index      <= '0;
            err_align    <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state      <= state_n;
            inflight   <= inflight_n;
            obuf_count <= obuf_n;
            wd         <= wd_n;
            if (s_hs) count <= (misalign || count == 5'd31) ? 5'd0 : count + 5'd1;
            if (s_hs && !misalign) fft_in_real[count*IN_W +: IN_W] <= s_data;
            if (capture) begin
                obuf_re[wr_ptr] <= fft_out_real;
                obuf_im[wr_ptr] <= fft_out_imag;
                wr_ptr          <= ~wr_ptr;
            end
            if (m_valid && m_ready) m_index <= m_index + 5'd1;
            if (retire) rd_ptr <= ~rd_ptr;
            err_align    <= err_align | misalign;
            err_timeout  <= err_timeout | trip;
            err_spurious <= err_spurious | (fft_out_valid && inflight == 2'd0);
        end
    end
endmodule

// File: tb/tb_fft32_frame_ctrl.sv
// tb_fft32_frame_ctrl: drives random sample/bin traffic through fft32_frame_ctrl with a behavioural FFT stand-in
// and a frame-level scoreboard (frames launched minus frames retired governs credit).
module tb_fft32_frame_ctrl;
    localparam int N = 32, IN_W = 8, OUT_W = 11, TIMEOUT = 64;
    typedef logic [N*IN_W-1:0] frame_t;
    typedef struct { frame_t f; int due; } pend_t;
    typedef struct { logic [OUT_W-1:0] re; logic [OUT_W-1:0] im; } bin_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic s_valid = 1'b0, s_ready, s_last = 1'b0, fft_in_valid, fft_out_valid = 1'b0;
    logic m_valid, m_ready = 1'b0, m_last, err_align, err_timeout, err_spurious;
    logic [IN_W-1:0] s_data = '0;
    logic [N*IN_W-1:0] fft_in_real;
    logic [N*OUT_W-1:0] fft_out_real = '0, fft_out_imag = '0;
    logic [OUT_W-1:0] m_real, m_imag;
    logic [4:0] m_index;

    fft32_frame_ctrl #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fft_in_valid(fft_in_valid), .fft_in_real(fft_in_real), .fft_out_valid(fft_out_valid),
        .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag), .m_valid(m_valid), .m_ready(m_ready),
        .m_real(m_real), .m_imag(m_imag), .m_index(m_index), .m_last(m_last),
        .err_align(err_align), .err_timeout(err_timeout), .err_spurious(err_spurious));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] cur[$];
    frame_t exp_frames[$], last_frame;
    pend_t pend[$];
    bin_t exp_bins[$];
    bit frame_ready, exp_align, prev_stall, silent, inject, out_spur;
    int t_hs, out_at_t, outstanding, captured, retired, launches, bins_out, bin_idx;
    int last_launch_cyc, first_retire_cyc = -1, ll_coinc, lat = 3, mr_mode = 1;
    logic [OUT_W-1:0] prev_re, prev_im;
    logic [4:0] prev_idx;

    task automatic clear_model();
        cur.delete(); exp_frames.delete(); pend.delete(); exp_bins.delete();
        frame_ready = 0; exp_align = 0; prev_stall = 0; inject = 0;
        outstanding = 0; captured = 0; retired = 0; bin_idx = 0;
    endtask

    // Scoreboard: per-cycle expectations come from frame counts, not from controller state
    always @(negedge clk) if (rst_n) begin
        bit exp_l;
        int out_pre;
        frame_t f;
        bin_t b;
        out_pre = outstanding;
        exp_l = frame_ready && ((cyc == t_hs + 1 && out_at_t < 2) || (cyc >= t_hs + 2 && out_pre < 2));
        checks++;
        if (fft_in_valid !== exp_l) begin failures++; $display("FAIL launch_timing cyc=%0d got=%b exp=%b", cyc, fft_in_valid, exp_l); end
        checks++;
        if (s_ready !== !frame_ready) begin failures++; $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, !frame_ready); end
        checks++;
        if (m_valid !== (captured > retired)) begin failures++; $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, captured > retired); end
        checks++;
        if (err_align !== exp_align) begin failures++; $display("FAIL err_align cyc=%0d got=%b exp=%b", cyc, err_align, exp_align); end
        if (prev_stall) begin
            checks++;
            if ({m_valid, m_real, m_imag, m_index} !== {1'b1, prev_re, prev_im, prev_idx}) begin
                failures++; $display("FAIL hold cyc=%0d got=%h/%h/%0d exp=%h/%h/%0d", cyc, m_real, m_imag, m_index, prev_re, prev_im, prev_idx);
            end
        end
        if (fft_in_valid) begin
            launches++; last_launch_cyc = cyc; last_frame = fft_in_real;
            if (fft_out_valid && !out_spur) ll_coinc++;
            checks++;
            if (exp_frames.size() == 0) begin failures++; $display("FAIL frame_unexpected cyc=%0d got=%h exp=none", cyc, fft_in_real); end
            else begin
                f = exp_frames.pop_front();
                if (fft_in_real !== f) begin failures++; $display("FAIL frame_data cyc=%0d got=%h exp=%h", cyc, fft_in_real, f); end
            end
            frame_ready = 0; outstanding++;
            if (!silent) pend.push_back('{fft_in_real, cyc + lat});
        end
        if (fft_out_valid && !out_spur) captured++;
        if (m_valid && m_ready) begin
            checks++;
            if (exp_bins.size() == 0) begin failures++; $display("FAIL bin_unexpected cyc=%0d got=%h/%h exp=none", cyc, m_real, m_imag); end
            else begin
                b = exp_bins.pop_front();
                if ({m_real, m_imag} !== {b.re, b.im}) begin failures++; $display("FAIL bin_data cyc=%0d got=%h/%h exp=%h/%h", cyc, m_real, m_imag, b.re, b.im); end
            end
            checks++;
            if (m_index !== 5'(bin_idx) || m_last !== (bin_idx == 31)) begin
                failures++; $display("FAIL bin_index cyc=%0d got=%0d/%b exp=%0d/%b", cyc, m_index, m_last, bin_idx, bin_idx == 31);
            end
            bins_out++;
            if (bin_idx == 31) begin retired++; outstanding--; if (first_retire_cyc < 0) first_retire_cyc = cyc; end
            bin_idx = (bin_idx + 1) % 32;
        end
        if (s_valid && s_ready) begin
            cur.push_back(s_data);
            if (s_last && cur.size() != 32) begin cur.delete(); exp_align = 1; end
            else if (cur.size() == 32) begin
                for (int k = 0; k < 32; k++) f[k*8 +: 8] = cur[k];
                exp_frames.push_back(f); frame_ready = 1; t_hs = cyc; out_at_t = out_pre; cur.delete();
            end
        end
        prev_stall = m_valid && !m_ready; prev_re = m_real; prev_im = m_imag; prev_idx = m_index;
    end

    // FFT stand-in: bins are a simple invertible function of the frame plus a random salt
    initial forever begin
        pend_t p;
        logic [OUT_W-1:0] sr, si;
        @(posedge clk); #1;
        fft_out_valid = 0; out_spur = 0;
        if (inject) begin
            inject = 0; fft_out_valid = 1; out_spur = 1;
            for (int k = 0; k < N; k++) begin fft_out_real[k*OUT_W +: OUT_W] = 11'($urandom); fft_out_imag[k*OUT_W +: OUT_W] = 11'($urandom); end
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front(); sr = 11'($urandom); si = 11'($urandom);
            for (int k = 0; k < N; k++) begin
                fft_out_real[k*OUT_W +: OUT_W] = {p.f[k*8 +: 8], 3'(k)} ^ sr;
                fft_out_imag[k*OUT_W +: OUT_W] = {5'(k), p.f[k*8 +: 6]} ^ si;
                exp_bins.push_back('{{p.f[k*8 +: 8], 3'(k)} ^ sr, {5'(k), p.f[k*8 +: 6]} ^ si});
            end
            fft_out_valid = 1;
        end
        m_ready = (mr_mode == 2) ? ($urandom_range(0, 3) != 0) : (mr_mode == 1);
    end

    task automatic send(input logic [7:0] d, input bit last);
        int n = 0;
        s_valid = 1; s_data = d; s_last = last;
        while (1) begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            if (++n > 2000) begin checks++; failures++; $display("FAIL send_timeout got=stalled exp=accept"); break; end
        end
        @(posedge clk); #1;
        s_valid = 0; s_last = 0;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int k = 0; k < 32; k++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send(8'($urandom), k == 31);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (frame_ready || exp_frames.size() > 0 || pend.size() > 0 || exp_bins.size() > 0 || captured != retired) begin
            @(posedge clk); #1;
            if (++n > 5000) begin checks++; failures++; $display("FAIL drain_timeout got=busy exp=idle"); break; end
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #3; rst_n = 0; clear_model();
        repeat (2) @(posedge clk); #1; rst_n = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({s_ready, fft_in_valid, m_valid, m_last, err_align, err_timeout, err_spurious} !== 7'b1000000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=1000000", {s_ready, fft_in_valid, m_valid, m_last, err_align, err_timeout, err_spurious});
        end
        checks++;
        if (fft_in_real !== '0) begin failures++; $display("FAIL reset_frame got=%h exp=0", fft_in_real); end
        checks++;
        if ({m_real, m_imag, m_index} !== '0) begin failures++; $display("FAIL reset_bin got=%h/%h/%0d exp=0/0/0", m_real, m_imag, m_index); end
        clear_model(); rst_n = 1;
    endtask

    task automatic test_single_frame();
        int l0 = launches, b0 = bins_out, th;
        frame_t ef;
        mr_mode = 1; lat = 3;
        for (int k = 0; k < 32; k++) begin ef[k*8 +: 8] = 8'(k + 1); send(8'(k + 1), k == 31); end
        th = t_hs;
        drain();
        checks++;
        if (launches != l0 + 1) begin failures++; $display("FAIL single_launches got=%0d exp=%0d", launches - l0, 1); end
        checks++;
        if (last_launch_cyc != th + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", last_launch_cyc - th, 1); end
        checks++;
        if (last_frame !== ef) begin failures++; $display("FAIL single_slots got=%h exp=%h", last_frame, ef); end
        checks++;
        if (bins_out != b0 + 32) begin failures++; $display("FAIL single_bins got=%0d exp=32", bins_out - b0); end
    endtask

    task automatic test_back_to_back();
        int l0 = launches;
        mr_mode = 0; lat = 5; first_retire_cyc = -1;
        repeat (3) send_frame(0);
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (launches != l0 + 2) begin failures++; $display("FAIL b2b_held_launches got=%0d exp=2", launches - l0); end
        checks++;
        if ({s_ready, m_valid} !== 2'b01) begin failures++; $display("FAIL b2b_wait got=%b exp=01", {s_ready, m_valid}); end
        mr_mode = 1;
        drain();
        checks++;
        if (launches != l0 + 3) begin failures++; $display("FAIL b2b_launches got=%0d exp=3", launches - l0); end
        checks++;
        if (last_launch_cyc != first_retire_cyc + 1) begin failures++; $display("FAIL b2b_credit_latency got=%0d exp=1", last_launch_cyc - first_retire_cyc); end
    endtask

    task automatic test_misalign();
        int l0 = launches;
        logic [7:0] d11 = 8'($urandom);
        mr_mode = 1; lat = 4;
        for (int k = 0; k < 10; k++) send(8'($urandom), k == 9);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({err_align, launches == l0} !== 2'b11) begin failures++; $display("FAIL misalign_flag got=%b exp=11", {err_align, launches == l0}); end
        for (int k = 0; k < 32; k++) send(k == 0 ? d11 : 8'($urandom), k == 31);
        drain();
        checks++;
        if (launches != l0 + 1) begin failures++; $display("FAIL misalign_launch got=%0d exp=1", launches - l0); end
        checks++;
        if (last_frame[7:0] !== d11 || err_align !== 1'b1) begin failures++; $display("FAIL misalign_slot0 got=%h/%b exp=%h/1", last_frame[7:0], err_align, d11); end
    endtask

    task automatic test_simultaneous();
        int c0 = ll_coinc, b0 = bins_out;
        mr_mode = 1; lat = 33;
        repeat (3) send_frame(0);
        drain();
        checks++;
        if (ll_coinc - c0 < 1) begin failures++; $display("FAIL simul_coincide got=%0d exp>=1", ll_coinc - c0); end
        checks++;
        if (bins_out != b0 + 96) begin failures++; $display("FAIL simul_bins got=%0d exp=96", bins_out - b0); end
        b0 = bins_out; mr_mode = 2;
        for (int f = 0; f < 5; f++) begin lat = $urandom_range(1, 40); send_frame(20); end
        drain();
        checks++;
        if (bins_out != b0 + 160) begin failures++; $display("FAIL random_bins got=%0d exp=160", bins_out - b0); end
    endtask

    task automatic test_watchdog();
        int l0, n = 0;
        do_reset();
        mr_mode = 1; silent = 1; l0 = launches;
        send_frame(0);
        while (launches == l0) begin
            @(posedge clk); #1;
            if (++n > 200) begin checks++; failures++; $display("FAIL wd_launch_timeout got=none exp=launch"); break; end
        end
        repeat (TIMEOUT - 4) begin @(posedge clk); #1; end
        checks++;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL wd_early got=%b exp=0", err_timeout); end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if ({err_timeout, err_spurious} !== 2'b10 || dut.inflight !== 2'd0) begin
            failures++; $display("FAIL wd_trip got=%b%b/%0d exp=10/0", err_timeout, err_spurious, dut.inflight);
        end
        inject = 1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({err_spurious, m_valid} !== 2'b10) begin failures++; $display("FAIL wd_spurious got=%b exp=10", {err_spurious, m_valid}); end
        silent = 0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        int n = 0, l0, b0;
        mr_mode = 0; lat = 2;
        send_frame(0);
        while (m_valid !== 1'b1) begin
            @(posedge clk); #1;
            if (++n > 200) begin checks++; failures++; $display("FAIL rmid_fill got=%b exp=1", m_valid); break; end
        end
        for (int k = 0; k < 17; k++) send(8'($urandom), 1'b0);
        #2; rst_n = 0; #1;
        checks++;
        if ({s_ready, fft_in_valid, m_valid, m_last, err_align, err_timeout, err_spurious} !== 7'b1000000) begin
            failures++; $display("FAIL rmid_ctrl got=%b exp=1000000", {s_ready, fft_in_valid, m_valid, m_last, err_align, err_timeout, err_spurious});
        end
        checks++;
        if (fft_in_real !== '0 || {m_real, m_imag, m_index} !== '0) begin failures++; $display("FAIL rmid_data got=%h/%h/%h exp=0", fft_in_real, m_real, m_imag); end
        clear_model();
        repeat (2) @(posedge clk); #1; rst_n = 1;
        mr_mode = 1; l0 = launches; b0 = bins_out;
        send_frame(0);
        drain();
        checks++;
        if (launches != l0 + 1 || bins_out != b0 + 32) begin failures++; $display("FAIL rmid_recover got=%0d/%0d exp=1/32", launches - l0, bins_out - b0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_misalign();
        test_simultaneous();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
